// File: rtl/fsm_debug_ctrl_if.sv
// Host command channel of the FSM debug controller: request/accept handshake,
// command fields, and the abort line.
interface fsm_debug_ctrl_if #(
    parameter int STATE_W = 4,
    parameter int X_W     = 2,
    parameter int CNT_W   = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [CNT_W-1:0]   cmd_count;
    logic [X_W-1:0]     cmd_x;
    logic [STATE_W-1:0] cmd_bp;
    logic               halt;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_x, cmd_bp, halt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_x, cmd_bp, halt,
        output cmd_ready
    );
endinterface

// File: rtl/fsm_debug_ctrl.sv
// Debug controller for a stepped FSM core: single step, N-step run and
// run-to-breakpoint, with a circular trace of {state, z} for every step taken.
module fsm_debug_ctrl #(
    parameter int STATE_W     = 4,
    parameter int Z_W         = 4,
    parameter int X_W         = 2,
    parameter int CNT_W       = 8,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    fsm_debug_ctrl_if.slave               host,
    input  logic [STATE_W-1:0]            dut_state,
    input  logic [Z_W-1:0]                dut_z,
    output logic                          dut_clk_enable,
    output logic [X_W-1:0]                dut_x,
    output logic                          busy,
    output logic                          done,
    output logic                          bp_hit,
    output logic                          timeout,
    output logic [CNT_W-1:0]              step_total,
    input  logic                          trace_rd_en,
    output logic [STATE_W+Z_W-1:0]        trace_rd_data,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          trace_empty,
    output logic                          trace_ovf
);
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int EW = STATE_W + Z_W;
    localparam logic [PW:0]      FULL_CNT = (PW+1)'(TRACE_DEPTH);
    localparam logic [PW:0]      CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [1:0] OP_STEP = 2'b00, OP_RUN_N = 2'b01, OP_RUN_BP = 2'b10;

    typedef enum logic [1:0] {IDLE, STEP, RUN, RUNBP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [STATE_W-1:0] bp_q;
    logic               taken;
    logic               accept;
    logic               bp_match;
    logic               step_en;

    logic [EW-1:0]      mem [TRACE_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop, full;

    assign host.cmd_ready = (state == IDLE);
    assign busy           = (state != IDLE);
    assign accept         = host.cmd_valid && host.cmd_ready;
    assign bp_match       = taken && (dut_state == bp_q);

    // The enable is decoded from state so halt, breakpoint and async reset act within the cycle.
    always_comb begin
        step_en = 1'b0;
        case (state)
            STEP:    step_en = !host.halt;
            RUN:     step_en = !host.halt;
            RUNBP:   step_en = !host.halt && !bp_match && (remaining != '0);
            default: step_en = 1'b0;
        endcase
    end
    assign dut_clk_enable = step_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dut_x   <= '0;
            taken   <= 1'b0;
            done    <= 1'b0;
            bp_hit  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            done    <= 1'b0;
            bp_hit  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    dut_x <= host.cmd_x;
                    taken <= 1'b0;
                    case (host.cmd_op)
                        OP_STEP:   state <= STEP;
                        OP_RUN_N:  if (host.cmd_count == '0) done <= 1'b1;
                                   else state <= RUN;
                        OP_RUN_BP: if (host.cmd_count == '0) begin
                                       done    <= 1'b1;
                                       timeout <= 1'b1;
                                   end else state <= RUNBP;
                        default:   done <= 1'b1;
                    endcase
                end
                STEP: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                RUN: if (host.halt || remaining == ONE) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                RUNBP: begin
                    if (host.halt) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (bp_match) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        bp_hit <= 1'b1;
                    end else if (remaining == '0) begin
                        state   <= IDLE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        taken <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command operands are only consulted while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            remaining <= host.cmd_count;
            bp_q      <= host.cmd_bp;
        end else if (step_en) begin
            remaining <= remaining - ONE;
        end
    end

    assign push        = step_en;
    assign full        = (trace_count == FULL_CNT);
    assign pop         = trace_rd_en && (trace_count != '0);
    assign trace_empty = (trace_count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {dut_state, dut_z};
    end

    // When full, a push lands on the oldest slot, so the read pointer must advance with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            trace_count   <= '0;
            trace_ovf     <= 1'b0;
            trace_rd_data <= '0;
            step_total    <= '0;
        end else begin
            if (pop) trace_rd_data <= mem[rd_ptr];
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                step_total <= step_total + ONE;
                if (full) trace_ovf <= 1'b1;
            end
            if (pop || (push && full)) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop && !full) trace_count <= trace_count + CNT_ONE;
            else if (pop && !push)     trace_count <= trace_count - CNT_ONE;
        end
    end
endmodule

// File: tb/tb_fsm_debug_ctrl.sv
// Bench for fsm_debug_ctrl: a counter-style FSM core, a queue-based trace model
// checked every cycle, and per-command expectations derived from the run rules.
module tb_fsm_debug_ctrl;
    localparam int STATE_W = 4, Z_W = 4, X_W = 2, CNT_W = 8, TRACE_DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fsm_debug_ctrl_if #(.STATE_W(STATE_W), .X_W(X_W), .CNT_W(CNT_W)) host ();

    logic [3:0] core_s, core_z;
    logic       dut_clk_enable;
    logic [1:0] dut_x;
    logic       busy, done, bp_hit, timeout;
    logic [7:0] step_total;
    logic       trace_rd_en = 1'b0;
    logic [7:0] trace_rd_data;
    logic [4:0] trace_count;
    logic       trace_empty, trace_ovf;

    fsm_debug_ctrl #(.STATE_W(STATE_W), .Z_W(Z_W), .X_W(X_W), .CNT_W(CNT_W),
                     .TRACE_DEPTH(TRACE_DEPTH)) dut (
        .clk(clk), .reset(reset), .host(host),
        .dut_state(core_s), .dut_z(core_z),
        .dut_clk_enable(dut_clk_enable), .dut_x(dut_x),
        .busy(busy), .done(done), .bp_hit(bp_hit), .timeout(timeout),
        .step_total(step_total), .trace_rd_en(trace_rd_en),
        .trace_rd_data(trace_rd_data), .trace_count(trace_count),
        .trace_empty(trace_empty), .trace_ovf(trace_ovf)
    );

    // FSM core: state advances by x per enabled step, Mealy z = state + x - 1.
    always @(posedge clk or negedge reset) begin
        if (!reset) core_s <= 4'd0;
        else if (dut_clk_enable) core_s <= core_s + {2'b00, dut_x};
    end
    assign core_z = core_s + {2'b00, dut_x} - 4'd1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Trace / counter model.
    logic [7:0] mq[$];
    int         m_total = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_rd = 8'h00;

    always @(negedge clk) begin
        logic [7:0] dummy;
        bit was_full;
        if (!reset) begin
            check("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
            check("rst_enable", 32'(dut_clk_enable), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_flags", 32'({done, bp_hit, timeout}), 32'd0);
            check("rst_dut_x", 32'(dut_x), 32'd0);
            check("rst_step_total", 32'(step_total), 32'd0);
            check("rst_trace_count", 32'(trace_count), 32'd0);
            check("rst_trace_empty", 32'(trace_empty), 32'd1);
            check("rst_trace_ovf", 32'(trace_ovf), 32'd0);
            check("rst_rd_data", 32'(trace_rd_data), 32'd0);
            mq.delete();
            m_total = 0;
            m_ovf = 1'b0;
            m_rd = 8'h00;
        end else begin
            check("trace_count", 32'(trace_count), 32'(mq.size()));
            check("trace_empty", 32'(trace_empty), 32'(mq.size() == 0));
            check("trace_ovf", 32'(trace_ovf), 32'(m_ovf));
            check("step_total", 32'(step_total), 32'(m_total % 256));
            check("trace_rd_data", 32'(trace_rd_data), 32'(m_rd));
            was_full = (mq.size() == TRACE_DEPTH);
            if (trace_rd_en && mq.size() > 0) m_rd = mq.pop_front();
            if (dut_clk_enable) begin
                if (was_full) m_ovf = 1'b1;
                mq.push_back({core_s, core_z});
                if (mq.size() > TRACE_DEPTH) dummy = mq.pop_front();
                m_total++;
            end
        end
    end

    bit rand_pop = 1'b0;
    bit pop_req = 1'b0;
    always begin
        @(posedge clk);
        #2;
        trace_rd_en = rand_pop ? ($urandom_range(0, 3) == 0) : pop_req;
    end

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(posedge clk); #1 pop_req = 1'b1;
        @(posedge clk); #1 pop_req = 1'b0;
        @(negedge clk);
        check(name, 32'(trace_rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
    endtask

    // Issues one command and checks enables, latency, flags and final core state.
    task automatic run_cmd(input logic [1:0] op, input int count, input logic [1:0] x,
                           input logic [3:0] bp, input int halt_after,
                           output int o_ens, output bit o_bp, output bit o_to);
        logic [3:0] s0;
        int n, lat, ens, cyc, lat_seen;
        bit e_bp, e_to, got, halted, use_halt, f_bp, f_to;
        s0 = core_s;
        e_bp = 0; e_to = 0; f_bp = 0; f_to = 0;
        use_halt = (op == 2'b01) && (halt_after >= 0) && (halt_after < count);
        case (op)
            2'b00: begin n = 1; lat = 2; end
            2'b01: begin
                if (count == 0) begin n = 0; lat = 1; end
                else if (use_halt) begin n = halt_after; lat = halt_after + 2; end
                else begin n = count; lat = count + 1; end
            end
            2'b10: begin
                if (count == 0) begin n = 0; lat = 1; e_to = 1; end
                else begin
                    n = count; lat = count + 2; e_to = 1;
                    for (int k = 1; k <= count; k++) begin
                        if (((int'(s0) + k * int'(x)) % 16) == int'(bp)) begin
                            n = k; lat = k + 2; e_to = 0; e_bp = 1;
                            break;
                        end
                    end
                end
            end
            default: begin n = 0; lat = 1; end
        endcase

        @(posedge clk); #1;
        check("cmd_ready_idle", 32'(host.cmd_ready), 32'd1);
        host.cmd_valid = 1'b1;
        host.cmd_op    = op;
        host.cmd_count = CNT_W'(count);
        host.cmd_x     = x;
        host.cmd_bp    = bp;
        @(posedge clk); #1;
        host.cmd_valid = 1'b0;
        host.cmd_x     = ~x;
        host.cmd_bp    = ~bp;

        cyc = 1; ens = 0; got = 0; halted = 0; lat_seen = -1;
        while (!got && cyc <= 400) begin
            host.halt = use_halt && !halted && (ens == halt_after);
            if (host.halt) halted = 1;
            @(negedge clk);
            if (dut_clk_enable) begin
                ens++;
                check("dut_x_hold", 32'(dut_x), 32'(x));
            end
            check("busy", 32'(busy), 32'(!done));
            if (done) begin
                got = 1; lat_seen = cyc; f_bp = bp_hit; f_to = timeout;
            end else begin
                check("flags_quiet", 32'({bp_hit, timeout}), 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        host.halt = 1'b0;
        if (!got) check("done_seen", 32'd0, 32'd1);
        check("enable_count", 32'(ens), 32'(n));
        check("done_latency", 32'(lat_seen), 32'(lat));
        check("bp_hit", 32'(f_bp), 32'(e_bp));
        check("timeout", 32'(f_to), 32'(e_to));
        check("core_state", 32'(core_s), 32'((int'(s0) + n * int'(x)) % 16));
        o_ens = ens; o_bp = f_bp; o_to = f_to;
    endtask

    initial begin
        int ens;
        bit fb, ft;
        logic [1:0] rop;
        host.cmd_valid = 1'b0;
        host.cmd_op    = 2'b00;
        host.cmd_count = '0;
        host.cmd_x     = '0;
        host.cmd_bp    = '0;
        host.halt      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_cmd(2'b00, 0, 2'b01, 4'd0, -1, ens, fb, ft);
        check("step_ens_lit", 32'(ens), 32'd1);
        check("step_core_lit", 32'(core_s), 32'd1);
        check("step_total_lit", 32'(step_total), 32'd1);
        pop_check("step_trace_lit", 8'h00);

        do_reset();
        run_cmd(2'b01, 5, 2'b01, 4'd0, -1, ens, fb, ft);
        check("run5_core_lit", 32'(core_s), 32'd5);
        for (int i = 0; i < 5; i++) pop_check("run5_trace_lit", 8'(i * 17));
        run_cmd(2'b01, 0, 2'b01, 4'd0, -1, ens, fb, ft);
        check("run0_ens_lit", 32'(ens), 32'd0);

        do_reset();
        run_cmd(2'b10, 20, 2'b01, 4'd9, -1, ens, fb, ft);
        check("bp9_ens_lit", 32'(ens), 32'd9);
        check("bp9_hit_lit", 32'(fb), 32'd1);
        run_cmd(2'b10, 20, 2'b01, 4'd9, -1, ens, fb, ft);
        check("bp9_wrap_ens_lit", 32'(ens), 32'd16);
        check("bp9_wrap_core_lit", 32'(core_s), 32'd9);
        check("bp9_total_lit", 32'(step_total), 32'd25);

        do_reset();
        run_cmd(2'b10, 4, 2'b01, 4'd9, -1, ens, fb, ft);
        check("lim4_ens_lit", 32'(ens), 32'd4);
        check("lim4_to_lit", 32'(ft), 32'd1);
        check("lim4_core_lit", 32'(core_s), 32'd4);
        do_reset();
        run_cmd(2'b10, 3, 2'b00, 4'd5, -1, ens, fb, ft);
        check("x0_ens_lit", 32'(ens), 32'd3);
        check("x0_to_lit", 32'(ft), 32'd1);
        check("x0_core_lit", 32'(core_s), 32'd0);

        do_reset();
        run_cmd(2'b01, 20, 2'b01, 4'd0, -1, ens, fb, ft);
        check("ovf_count_lit", 32'(trace_count), 32'd16);
        check("ovf_flag_lit", 32'(trace_ovf), 32'd1);
        for (int i = 0; i < 16; i++) pop_check("ovf_trace_lit", 8'(((4 + i) % 16) * 17));
        pop_check("pop_empty_lit", 8'h33);
        check("empty_lit", 32'(trace_empty), 32'd1);

        do_reset();
        run_cmd(2'b01, 100, 2'b01, 4'd0, 7, ens, fb, ft);
        check("halt_ens_lit", 32'(ens), 32'd7);
        check("halt_total_lit", 32'(step_total), 32'd7);
        check("halt_flags_lit", 32'({fb, ft}), 32'd0);

        @(posedge clk); #1;
        host.cmd_valid = 1'b1;
        host.cmd_op    = 2'b01;
        host.cmd_count = 8'd100;
        host.cmd_x     = 2'b01;
        @(posedge clk); #1 host.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("en_before_reset", 32'(dut_clk_enable), 32'd1);
        reset = 1'b0;
        #1;
        check("async_en_drop", 32'(dut_clk_enable), 32'd0);
        check("async_trace_count", 32'(trace_count), 32'd0);
        check("async_cmd_ready", 32'(host.cmd_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b1;

        run_cmd(2'b11, 9, 2'b10, 4'd3, -1, ens, fb, ft);
        check("reserved_ens_lit", 32'(ens), 32'd0);

        rand_pop = 1'b1;
        repeat (60) begin
            rop = 2'($urandom_range(0, 3));
            run_cmd(rop, $urandom_range(0, 40), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1,
                    ens, fb, ft);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_pop = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fsm_debug_ctrl.md
Name: fsm_debug_ctrl

Overview:
Debug-side controller that owns the clock-enable and input stimulus of a stepped FSM core, and observes its output and state. It runs single steps, N-step runs and run-to-breakpoint sequences on host command. Each executed step is captured as {state, z} in a circular trace buffer that the host reads out. It sits between the host/debug interface and the FSM core's clk_enable, x_in, z_out and current_state_debug pins.

Parameters:
STATE_W, 4, width of the observed FSM state
Z_W, 4, width of the observed FSM output
X_W, 2, width of the FSM input stimulus
CNT_W, 8, width of the step count and step-limit fields
TRACE_DEPTH, 16, trace entries; must be a power of 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 STEP, 01 RUN_N, 10 RUN_BP, 11 reserved (accepted, treated as a no-op)
cmd_count  in  CNT_W  step count (RUN_N) or step limit (RUN_BP)
cmd_x  in  X_W  stimulus applied for the whole command
cmd_bp  in  STATE_W  breakpoint state for RUN_BP
halt  in  1  abort the running command
dut_state  in  STATE_W  FSM present state
dut_z  in  Z_W  FSM output (Mealy, combinational)
dut_clk_enable  out  1  step enable to the FSM
dut_x  out  X_W  stimulus to the FSM
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
bp_hit  out  1  one-cycle pulse with done when the breakpoint stopped a run
timeout  out  1  one-cycle pulse with done when RUN_BP exhausted its limit
step_total  out  CNT_W  steps since reset; wraps modulo 2^CNT_W
trace_rd_en  in  1  pop the oldest trace entry
trace_rd_data  out  STATE_W+Z_W  registered {state, z}; valid the cycle after the pop
trace_count  out  log2(TRACE_DEPTH)+1  number of entries held
trace_empty  out  1  trace_count == 0
trace_ovf  out  1  sticky; set when an entry is overwritten; cleared only by reset

Behaviour:
- Reset, asynchronous: state IDLE. All outputs are 0 except cmd_ready = 1. Trace pointers and count = 0; trace_rd_data = 0.
- States: IDLE, STEP, RUN, RUNBP.
- On accept, latch cmd_x into the register driving dut_x, and latch cmd_count into remaining; latch cmd_bp.
  - STEP goes to STEP.
  - RUN_N goes to RUN, or completes in the next cycle with done and no enable if the count is 0.
  - RUN_BP goes to RUNBP, or completes in the next cycle with done and timeout if the count is 0.
  - Reserved op: done next cycle.
- dut_x holds its latched value until the next accepted command.
- A step is a cycle with dut_clk_enable = 1. First enable comes 1 cycle after accept.
- STEP: enable for exactly 1 cycle, then done and return to IDLE.
- RUN: enable every cycle, decrement remaining; the last step's cycle returns to IDLE with done.
- RUNBP, checked each cycle before enabling:
  - If at least one step has been taken this run and dut_state == latched bp: no enable; pulse done + bp_hit; go to IDLE. The state at run start never triggers.
  - Else if remaining == 0: no enable; pulse done + timeout; go to IDLE.
  - Else enable and decrement remaining.
- halt while busy: no enable that cycle; done next edge; return to IDLE. bp_hit and timeout stay low. halt in IDLE is ignored.
- Trace capture:
  - In every enabled cycle, push {dut_state, dut_z}, i.e. the pre-transition state and the Mealy output for that step.
  - step_total increments on every enabled cycle.
  - Push when full: overwrite the oldest entry, advance the read pointer, count stays at TRACE_DEPTH, set trace_ovf.
- Trace read:
  - trace_rd_en when empty: ignored; data and pointers are unchanged.
  - Simultaneous push and pop, not full: count unchanged.
  - Simultaneous push and pop, full: the pop returns the oldest entry; the push writes; count stays at TRACE_DEPTH and ovf is set.
- Reset mid-run: dut_clk_enable drops immediately (asynchronously); all state clears.

Test Plan:
- FSM core at S0, STEP with x=01 -> exactly 1 enable cycle; trace = {0x00}; core moves to S1; done 2 cycles after accept; step_total = 1.
- From S0, RUN_N count=5, x=01 -> 5 consecutive enables; trace pops return 0x00, 0x11, 0x22, 0x33, 0x44; core at S5; RUN_N count=0 -> done with no enable.
- From S0, RUN_BP bp=9 limit=20, x=01 -> 9 enables, then done + bp_hit; core at S9. Repeat with bp=9 from S9 -> runs the full cycle; stops on the return to S9 after 16 steps.
- From S0, RUN_BP bp=9 limit=4 -> 4 enables, then done + timeout; core at S4. With x=00 and bp=5 limit=3 -> 3 enables, timeout, core at S0.
- From S0, RUN_N count=20, x=01 -> trace_count = 16, trace_ovf = 1; oldest pop = 0x44; then 0x55 … 0xFF, 0x00 … 0x33 in order; pop on empty leaves trace_rd_data unchanged.
- RUN_N count=100; halt after 7 enables -> no further enable; done next cycle; step_total = 7. Reset asserted mid-run -> dut_clk_enable = 0 immediately; trace_count = 0; cmd_ready = 1.
